// File: rtl/cpu0_mem_wait.sv
// Byte-addressable big-endian memory for the cpu0 bus with req/ready handshake and WAIT wait states.
// Define MEM_IO_EN to map a 32-bit output port at IO_ADDR (io_data/io_valid); otherwise they read 0.
module cpu0_mem_wait #(
    parameter int unsigned DEPTH   = 28672,
    parameter int unsigned WAIT    = 2,
    parameter logic [31:0] IO_ADDR = 32'h7000,
    parameter logic [7:0]  EMPTY   = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] io_data,
    output logic        io_valid
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);
`ifdef MEM_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        do_access;

    logic        cap_we;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr, cap_wdata;

    logic        acc_we;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata;

    logic [2:0]  n_bytes;
    logic [32:0] end_addr;
    logic        in_range, io_match, io_wr_hit, io_rd_hit, out_of_range;
    logic [31:0] size_mask, rd_word, wdata_msb;
    logic [AW-1:0] byte_idx [4];
    logic [7:0]    wr_byte  [4];
    logic          wr_en    [4];

    // NOTE: the array is never reset; its power-up image comes from this initialiser, so reset cannot disturb stored data.
    logic [7:0] mem [0:DEPTH-1] = '{default: EMPTY};

    // With WAIT = 0 the access happens in the IDLE cycle itself, before the capture registers load.
    always_comb begin
        acc_we    = cap_we;
        acc_size  = cap_size;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        if (state == S_IDLE) begin
            acc_we    = we;
            acc_size  = size;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch appears.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_access  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT == 0) begin
                        state_next = S_ACCESS;
                        do_access  = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WAIT_CNT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = S_ACCESS;
                    do_access  = 1'b1;
                end
            end
            S_ACCESS: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Range check at 33 bits so an address near 2^32 cannot wrap back into the array.
    always_comb begin
        n_bytes      = {1'b0, acc_size} + 3'd1;
        end_addr     = {1'b0, acc_addr} + {30'd0, n_bytes};
        in_range     = end_addr <= 33'(DEPTH);
        io_match     = acc_addr == IO_ADDR;
        io_wr_hit    = IO_EN && io_match && acc_we && (acc_size == 2'b11);
        io_rd_hit    = IO_EN && io_match && !acc_we;
        out_of_range = !in_range && !io_wr_hit && !io_rd_hit;
        case (acc_size)
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            2'b10:   size_mask = 32'h00FF_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
        // Left-justify so byte i of the access is always wdata_msb[31-8i -: 8].
        wdata_msb = acc_wdata << {~acc_size, 3'b000};
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            byte_idx[i] = acc_addr[AW-1:0] + AW'(i);
            wr_byte[i]  = wdata_msb[31-8*i -: 8];
            wr_en[i]    = !reset && do_access && acc_we && in_range && !io_wr_hit
                          && (3'(i) < n_bytes);
            if (3'(i) < n_bytes) rd_word = {rd_word[23:0], mem[byte_idx[i]]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            cap_we    <= 1'b0;
            cap_size  <= 2'b00;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= do_access;
            err   <= do_access && out_of_range;
            if (state == S_IDLE && req) begin
                cap_we    <= we;
                cap_size  <= size;
                cap_addr  <= addr;
                cap_wdata <= wdata;
            end
            if (do_access) begin
                if (out_of_range)   rdata <= '0;
                else if (io_rd_hit) rdata <= io_data & size_mask;
                else if (!acc_we)   rdata <= rd_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) mem[byte_idx[i]] <= wr_byte[i];
        end
    end

`ifdef MEM_IO_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_data  <= '0;
            io_valid <= 1'b0;
        end else begin
            io_valid <= do_access && io_wr_hit;
            if (do_access && io_wr_hit) io_data <= acc_wdata;
        end
    end
`else
    assign io_data  = '0;
    assign io_valid = 1'b0;
`endif

endmodule

// File: doc/cpu0_mem_wait.md
# cpu0_mem_wait

Parametrised, byte-addressable, big-endian memory for the cpu0 system bus, with a request/ready handshake and a programmable number of wait states. It replaces the zero-latency combinational memory model and lets the CPU run against memories of arbitrary depth and latency. It also flags accesses outside the array and can optionally expose a memory-mapped output port.

## Interface
Parameters:
- DEPTH, 28672: memory size in bytes (0x7000).
- WAIT, 2: wait states per access, 0..15.
- IO_ADDR, 32'h7000: byte address of the output port, used only with MEM_IO_EN.
- EMPTY, 8'hFF: initial value of every byte at simulation start.

Ports. Reset is asynchronous and active-high on `reset`; the clock is `clock`.
- clock  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = write, 0 = read.
- size  in  2  access width: 00 byte, 01 half, 10 24-bit, 11 word.
- addr  in  32  byte address of the most significant byte.
- wdata  in  32  write data, right-aligned.
- rdata  out  32  read data, right-aligned and zero-extended.
- ready  out  1  one-cycle completion pulse.
- err  out  1  range error, valid only while ready = 1.
- io_data  out  32  last word written to IO_ADDR.
- io_valid  out  1  one-cycle pulse when io_data is updated.

## Operation
- The FSM has three states: IDLE, WAIT and ACCESS.
- IDLE: when req = 1, capture addr, we, size and wdata, load the counter with WAIT and go to WAIT. If WAIT = 0, go directly to ACCESS.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACCESS.
- ACCESS: perform the access, pulse ready, then return to IDLE.
- Requests arriving outside IDLE are ignored, never queued. The master must re-assert req after ready.
- An access covers n = size + 1 bytes, big-endian: byte at addr = most significant byte.
  - Reads return the bytes in bits [8n-1:0], with the upper bits set to 0.
  - Writes store wdata[8n-1:0].
- Unaligned addresses are legal.
- Range check: if addr + n > DEPTH, computed at 33-bit width so there is no wrap, then the access is out of range:
  - nothing is written;
  - rdata = 0;
  - err = 1 together with ready.
- rdata holds its value until the next ready pulse. Write accesses leave rdata unchanged.
- Memory contents are not affected by reset. Every byte is EMPTY at time 0.

## Timing
- Reset values: FSM in IDLE, counter 0, rdata 0, ready 0, err 0, io_data 0, io_valid 0.
- Latency: when req is sampled in cycle t, ready is high in cycle t + WAIT + 1.
- Throughput: the earliest next acceptance is the cycle after ready, which gives one access per WAIT + 2 cycles.
- ready, err and io_valid are registered and high for exactly one cycle.
- Reset asserted mid-access: the access is aborted, nothing is written, no ready is produced, and the FSM returns to IDLE.

## Configuration
- MEM_IO_EN defined:
  - A write with size = 11 and addr = IO_ADDR updates io_data with wdata and pulses io_valid together with ready. The array is not written and err = 0.
  - A read of IO_ADDR with any size returns io_data, truncated to width.
  - Writes to IO_ADDR with other sizes are performed as normal array accesses.
- MEM_IO_EN undefined:
  - io_data and io_valid are tied to 0.
  - IO_ADDR has no special meaning. At the default parameters it is out of range, so an access to it gives err = 1.

## Test plan
- Reset, then with WAIT = 2 write word 0x12345678 at address 0x10, then read bytes 0x10..0x13 → read data 0x12, 0x34, 0x56, 0x78. Each ready pulse occurs exactly 3 cycles after req is sampled.
- Write half 0xBEEF at address 0x21, then read word at 0x20 → rdata = 0xFFBEEFFF, which checks the unaligned write and that neighbouring bytes keep EMPTY.
- Read word at 0x6FFD with DEPTH = 0x7000 → ready with err = 1 and rdata = 0; a later read of 0x6FFC returns the original contents.
- With WAIT = 0, issue back-to-back requests with req held high → ready is asserted every 2nd cycle, and req asserted during ACCESS is ignored.
- Assert reset during WAIT of a write of 0xAAAAAAAA at 0x40 → no ready pulse, and a subsequent read of 0x40 returns 0xFFFFFFFF.
- With MEM_IO_EN, write word 0x0000002A at 0x7000 → io_valid pulses with io_data = 42, ready is asserted with err = 0, and a byte read of 0x7000 returns 0x2A.
